mul_div_sequencer: RTL and testbench

Iterative multiply/divide unit and its sequencer for the RISC-V core: executes the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over multiple cycles and stalls the rest of the pipeline while it runs. It sits beside the main ALU in the execute stage. The controller raises `Start` when an R-type instruction has Funct7 = 0000001. The result is muxed onto the ALU result path on the `Done` cycle.

---
 rtl/mul_div_sequencer_pkg.sv | 43 ++++
 rtl/mul_div_sequencer_if.sv | 28 ++
 rtl/mul_div_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   mdu_state_t   : sequencer states
//   mdu_op_t      : RV32M Funct3 operation codes
//   FUNCT7_MULDIV : Funct7 value that marks an R-type M-extension instruction
//   neg_w/neg_d   : two's-complement negation of single/double width values
//   abs_w         : magnitude of a value that may be interpreted as signed
package mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    function automatic logic [MDU_XLEN-1:0] neg_w(input logic [MDU_XLEN-1:0] x);
        return -x;
    endfunction

    function automatic logic [2*MDU_XLEN-1:0] neg_d(input logic [2*MDU_XLEN-1:0] x);
        return -x;
    endfunction

    function automatic logic [MDU_XLEN-1:0] abs_w(input logic [MDU_XLEN-1:0] x,
                                                  input logic                is_signed);
        return (is_signed && x[MDU_XLEN-1]) ? neg_w(x) : x;
    endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Execute-stage handshake between the core controller (master) and the
// multiply/divide unit (slave).
//   Start/Funct3/SrcA/SrcB : operation request and operands
//   Flush                  : abort of the in-flight operation
//   Stall                  : pipeline hold request from the unit
//   Done/Result            : one-cycle completion pulse and the result
interface mul_div_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            Flush;
    logic            Stall;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, Funct3, SrcA, SrcB, Flush,
        input  Stall, Done, Result
    );

    modport slave (
        input  Start, Funct3, SrcA, SrcB, Flush,
        output Stall, Done, Result
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// Iterative RV32M multiply/divide unit with its sequencer.
// Operands are reduced to magnitudes on acceptance, processed unsigned for
// XLEN cycles (shift-add multiply or restoring divide), then signs are
// applied in a single fix-up cycle before the result is registered.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mul_div_sequencer_if (Start/Funct3/SrcA/SrcB/Flush
//           in, Stall/Done/Result out)
module mul_div_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_div_sequencer_if.slave   bus
);

    localparam int unsigned CW = $clog2(XLEN);

    mdu_state_t        state_q, state_d;
    mdu_op_t           op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;       // product; low half is dividend/quotient
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              stall;
    logic              done;

    // Operand decode of the request currently presented in IDLE
    mdu_op_t           req_op;
    logic              req_div;
    logic              a_sgn, b_sgn;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   a_abs, b_abs;

    always_comb begin
        req_op  = mdu_op_t'(bus.Funct3);
        req_div = bus.Funct3[2];
        a_sgn   = req_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn   = req_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        neg_a   = a_sgn & bus.SrcA[XLEN-1];
        neg_b   = b_sgn & bus.SrcB[XLEN-1];
        a_abs   = abs_w(bus.SrcA, a_sgn);
        b_abs   = abs_w(bus.SrcB, b_sgn);
    end

    // Iteration temporaries
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_sub;
    logic              rem_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        stall     = 1'b0;
        done      = 1'b0;
        mul_sum   = '0;
        rem_shift = '0;
        rem_sub   = '0;
        rem_ge    = 1'b0;
        prod_fix  = '0;
        quo_fix   = '0;
        rem_fix   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    stall     = 1'b1;
                    op_d      = req_op;
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    cnt_d     = CW'(XLEN - 1);
                    opnd_d    = req_div ? b_abs : a_abs;
                    acc_d     = {{XLEN{1'b0}}, (req_div ? a_abs : b_abs)};
                    rem_d     = '0;
                    state_d   = CALC;
                    if (req_div) begin
                        if (bus.SrcB == '0) begin
                            result_d = bus.Funct3[1] ? bus.SrcA : '1;
                            state_d  = DONE;
                        end else if (b_sgn && bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}
                                     && bus.SrcB == '1) begin
                            result_d = bus.Funct3[1] ? '0 : bus.SrcA;
                            state_d  = DONE;
                        end
                    end
                end
            end

            CALC: begin
                stall = 1'b1;
                if (bus.Flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (op_q[2]) begin
                        // Restoring step: the 33-bit partial remainder is the
                        // stored remainder with the next dividend bit shifted in.
                        // The remainder stays below the divisor, so the low
                        // XLEN bits of the difference are exact.
                        rem_shift = {rem_q, acc_q[XLEN-1]};
                        rem_ge    = rem_shift >= {1'b0, opnd_q};
                        rem_sub   = rem_shift[XLEN-1:0] - opnd_q;
                        rem_d     = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
                        acc_d     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], rem_ge};
                    end else begin
                        // Shift-add: the multiplier sits in the low half and is
                        // consumed LSB first while the carry enters the top.
                        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                                + (acc_q[0] ? {1'b0, opnd_q} : '0);
                        acc_d   = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                stall = 1'b1;
                if (bus.Flush) begin
                    state_d = IDLE;
                end else begin
                    prod_fix = neg_res_q ? neg_d(acc_q) : acc_q;
                    quo_fix  = neg_res_q ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
                    rem_fix  = neg_rem_q ? neg_w(rem_q) : rem_q;
                    unique case (op_q)
                        OP_MUL:                       result_d = prod_fix[XLEN-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                        OP_DIV, OP_DIVU:              result_d = quo_fix;
                        default:                      result_d = rem_fix;
                    endcase
                    state_d = DONE;
                end
            end

            DONE: begin
                done    = !bus.Flush;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign bus.Stall  = stall;
    assign bus.Done   = done;
    assign bus.Result = result_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: reset values, every RV32M operation,
// special cases, back-to-back issue, flush behaviour and mid-operation reset.
module tb_mul_div_sequencer;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] last_res = '0;

    mul_div_sequencer_if #(.XLEN(32)) bus ();

    mul_div_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issue one operation and follow it to completion.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_cyc, input string name);
        int done_cyc;
        int bad_cyc;
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = f3; bus.SrcA = a; bus.SrcB = b;
        #1;
        n_total++;
        if (bus.Stall !== 1'b1) $display("FAIL %s stall_c0 got %b want 1", name, bus.Stall);
        else n_pass++;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        done_cyc = -1;
        bad_cyc  = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (bus.Stall !== (c < exp_cyc) && bad_cyc < 0) bad_cyc = c;
            if (bus.Done === 1'b1) begin done_cyc = c; break; end
        end
        n_total++;
        if (bad_cyc >= 0) $display("FAIL %s stall_profile wrong at cycle %0d want stall until %0d", name, bad_cyc, exp_cyc - 1);
        else n_pass++;
        n_total++;
        if (done_cyc != exp_cyc) $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_cyc);
        else n_pass++;
        n_total++;
        if (bus.Result !== exp) $display("FAIL %s result got %h want %h", name, bus.Result, exp);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (bus.Done !== 1'b0 || bus.Result !== exp)
            $display("FAIL %s after_done done=%b result=%h want 0 %h", name, bus.Done, bus.Result, exp);
        else n_pass++;
        last_res = exp;
    endtask

    task automatic test_reset();
        bus.Start = 1'b0; bus.Flush = 1'b0; bus.Funct3 = '0; bus.SrcA = '0; bus.SrcB = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus.Stall !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'h0)
            $display("FAIL reset outputs got stall=%b done=%b result=%h want 0 0 0", bus.Stall, bus.Done, bus.Result);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3");
        run_op(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min");
        run_op(OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 34, "mulhu_min");
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1");
    endtask

    task automatic test_div();
        run_op(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_m7_2");
        run_op(OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem_m7_2");
        run_op(OP_DIVU, 32'd100,      32'd7, 32'd14,       34, "divu_100_7");
        run_op(OP_REMU, 32'd100,      32'd7, 32'd2,        34, "remu_100_7");
    endtask

    task automatic test_special();
        run_op(OP_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 1, "divu_by0");
        run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf");
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        run_op(OP_REMU, 32'd5,        32'd0,        32'd5,        1, "remu_by0");
    endtask

    // Start held high: a new operation is taken at each IDLE cycle.
    task automatic test_back_to_back();
        int dones[$];
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = OP_MUL; bus.SrcA = 32'd3; bus.SrcB = 32'd5;
        for (int c = 1; c <= 75; c++) begin
            @(posedge clk); #1;
            if (bus.Done === 1'b1) dones.push_back(c);
        end
        bus.Start = 1'b0; bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        n_total++;
        if (dones.size() != 2 || dones[0] != 34 || dones[1] != 69)
            $display("FAIL b2b done_cycles got n=%0d first=%0d second=%0d want 34 69", dones.size(),
                     dones.size() > 0 ? dones[0] : -1, dones.size() > 1 ? dones[1] : -1);
        else n_pass++;
        n_total++;
        if (bus.Result !== 32'd15) $display("FAIL b2b result got %h want %h", bus.Result, 32'd15);
        else n_pass++;
        n_total++;
        if (bus.Stall !== 1'b0) $display("FAIL b2b flush_stall got %b want 0", bus.Stall);
        else n_pass++;
        last_res = 32'd15;
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = OP_MUL; bus.SrcA = 32'd6; bus.SrcB = 32'd7;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int c = 2; c <= 10; c++) begin @(posedge clk); #1; end
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        n_total++;
        if (bus.Stall !== 1'b0 || bus.Done !== 1'b0)
            $display("FAIL flush_c11 stall=%b done=%b want 0 0", bus.Stall, bus.Done);
        else n_pass++;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.Done === 1'b1 || bus.Stall === 1'b1) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL flush_quiet got %0d active cycles want 0", seen);
        else n_pass++;
        n_total++;
        if (bus.Result !== last_res) $display("FAIL flush_result got %h want %h", bus.Result, last_res);
        else n_pass++;

        @(negedge clk);
        bus.Start = 1'b1; bus.Flush = 1'b1; bus.Funct3 = OP_DIVU; bus.SrcA = 32'd9; bus.SrcB = 32'd0;
        #1;
        n_total++;
        if (bus.Stall !== 1'b0) $display("FAIL start_flush_stall got %b want 0", bus.Stall);
        else n_pass++;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.Flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.Done === 1'b1 || bus.Stall === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_total++;
        if (seen != 0 || bus.Result !== last_res)
            $display("FAIL start_flush_ignored active=%0d result=%h want 0 %h", seen, bus.Result, last_res);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = OP_DIV; bus.SrcA = 32'd1000; bus.SrcB = 32'd10;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int c = 2; c <= 20; c++) begin @(posedge clk); #1; end
        n_total++;
        if (bus.Stall !== 1'b1) $display("FAIL rstmid_busy stall got %b want 1", bus.Stall);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.Stall !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'h0)
            $display("FAIL rstmid_outputs stall=%b done=%b result=%h want 0 0 0", bus.Stall, bus.Done, bus.Result);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_DIV, 32'd20, 32'd3, 32'd6, 34, "div_20_3_after_rst");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
